// File: rtl/tt_proj_sel_ctrl.sv
// tt_proj_sel_ctrl
// Shares the chip-level project I/O bus between N_PROJ tile wrappers.
// A select request walks the active slot through gate -> switch ->
// reset-hold -> run, so a project never sees its enable change while its
// clock is running. The active project's 24-bit output word is muxed to
// ow_out.
//
// Control outputs are registered from the current state. They therefore
// follow the state by one cycle: a request accepted at edge T raises
// active at edge T+GATE_CYC+RST_HOLD+2. proj_ena changes on the edge that
// leaves SWITCH, while proj_clk_en still shows the gated value.
//
// Optional build macro: TT_SEL_OW_REG_EN
//   defined   - ow_out is registered (one cycle after active rises, and
//               cleared on the edge where active falls)
//   undefined - ow_out is a combinational mux gated by active
module tt_proj_sel_ctrl #(
  parameter int N_PROJ   = 24,
  parameter int SEL_W    = 5,
  parameter int GATE_CYC = 2,
  parameter int RST_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel_valid,
  output logic                 sel_ready,
  input  logic [SEL_W-1:0]     sel_addr,
  output logic [N_PROJ-1:0]    proj_ena,
  output logic                 proj_clk_en,
  output logic                 proj_rst_n,
  input  logic [24*N_PROJ-1:0] ow_bus,
  output logic [23:0]          ow_out,
  output logic [SEL_W-1:0]     cur_addr,
  output logic                 active,
  output logic                 err
);

  localparam int CNT_MAX = (GATE_CYC > RST_HOLD) ? GATE_CYC : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_SWITCH  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   r_pend_addr;
  logic [N_PROJ-1:0]  r_ena;
  logic [N_PROJ-1:0]  w_ena_nxt;
  logic [SEL_W-1:0]   r_cur_addr;
  logic [SEL_W-1:0]   w_cur_nxt;
  logic               r_clk_en;
  logic               w_clk_en_nxt;
  logic               r_rst_n;
  logic               w_rst_n_nxt;
  logic               r_active;
  logic               w_active_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               w_ready;
  logic               w_xfer;
  logic               w_addr_ok;
  logic [23:0]        w_slice;

  assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_xfer    = sel_valid && w_ready;
  assign w_addr_ok = (32'(sel_addr) < 32'(N_PROJ));

  // State register and dwell counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; the counter restarts at zero on every state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        w_cnt_nxt = '0;
        if (w_xfer && w_addr_ok) begin
          w_state_nxt = ST_QUIESCE;
        end else if (w_xfer) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_QUIESCE: begin
        if (r_cnt == GATE_LAST) begin
          w_state_nxt = ST_SWITCH;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_QUIESCE;
        end
      end
      ST_SWITCH: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = '0;
      end
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output targets decoded from the current state.
  always_comb begin
    w_ena_nxt    = r_ena;
    w_cur_nxt    = r_cur_addr;
    w_clk_en_nxt = 1'b0;
    w_rst_n_nxt  = 1'b0;
    w_active_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ena_nxt = '0;
      end
      ST_QUIESCE: begin
        w_ena_nxt = r_ena;
      end
      ST_SWITCH: begin
        w_ena_nxt = N_PROJ'(1) << r_pend_addr;
        w_cur_nxt = r_pend_addr;
      end
      ST_HOLD: begin
        w_clk_en_nxt = 1'b1;
      end
      ST_RUN: begin
        w_clk_en_nxt = 1'b1;
        w_rst_n_nxt  = 1'b1;
        w_active_nxt = 1'b1;
      end
      default: begin
        w_ena_nxt = '0;
      end
    endcase
  end

  // Registered project controls and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ena      <= '0;
      r_cur_addr <= '0;
      r_clk_en   <= 1'b0;
      r_rst_n    <= 1'b0;
      r_active   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ena      <= w_ena_nxt;
      r_cur_addr <= w_cur_nxt;
      r_clk_en   <= w_clk_en_nxt;
      r_rst_n    <= w_rst_n_nxt;
      r_active   <= w_active_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Pending address captured on every accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_addr <= '0;
    end else if (w_xfer) begin
      r_pend_addr <= sel_addr;
    end else begin
      r_pend_addr <= r_pend_addr;
    end
  end

  // Slot mux: pick the 24-bit word of the current project.
  always_comb begin
    w_slice = 24'h0;
    for (int i = 0; i < N_PROJ; i++) begin
      w_slice = (r_cur_addr == SEL_W'(i)) ? ow_bus[24*i +: 24] : w_slice;
    end
  end

`ifdef TT_SEL_OW_REG_EN
  logic [23:0] r_ow;

  // Registered output word, cleared on the same edge active falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ow <= 24'h0;
    end else if (r_active && w_active_nxt) begin
      r_ow <= w_slice;
    end else begin
      r_ow <= 24'h0;
    end
  end

  assign ow_out = r_ow;
`else
  assign ow_out = r_active ? w_slice : 24'h0;
`endif

  assign sel_ready   = w_ready;
  assign proj_ena    = r_ena;
  assign proj_clk_en = r_clk_en;
  assign proj_rst_n  = r_rst_n;
  assign cur_addr    = r_cur_addr;
  assign active      = r_active;
  assign err         = r_err;

endmodule
